// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP TX engine between NUM_CH packet sources.
// Launches one packet at a time, rejects illegal lengths, and enforces an inter-frame gap.
module udp_tx_scheduler #(
   parameter int NUM_CH      = 2,
   parameter int IFG_CYCLES  = 16,
   parameter int TIMEOUT_CYC = 4096,
   parameter int MAX_LEN     = 1472
) (
   input  logic                 clk_125m,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH*16-1:0] ch_len,
   input  logic [NUM_CH*16-1:0] ch_dst_port,
   input  logic [NUM_CH*8-1:0]  ch_payload_dat,
   output logic [NUM_CH-1:0]    ch_grant,
   output logic [NUM_CH-1:0]    ch_payload_req,
   output logic [NUM_CH-1:0]    ch_done,
   output logic                 tx_en_pulse,
   output logic [15:0]          tx_data_length,
   output logic [15:0]          tx_dst_port,
   input  logic                 tx_done,
   input  logic                 payload_req_i,
   output logic [7:0]           payload_dat_o,
   output logic                 busy,
   output logic                 len_err,
   output logic                 err_timeout
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
   localparam int GAP_W = $clog2(IFG_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [NUM_CH-1:0]   r_grant;
   logic [NUM_CH-1:0]   r_done;
   logic                r_tx_en;
   logic [15:0]         r_len;
   logic [15:0]         r_port;
   logic                r_len_err;
   logic                r_err_to;
   logic [TO_W-1:0]     r_to_cnt;
   logic [GAP_W-1:0]    r_gap_cnt;

   logic                w_win_vld;
   logic [IDX_W-1:0]    w_win_idx;
   logic [15:0]         w_win_len;
   logic [15:0]         w_win_port;
   logic                w_len_ok;
   logic [7:0]          w_dat;

   function automatic int wrap_idx(input int base, input int k);
      return (base + k) % NUM_CH;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
      if (int'(w) == NUM_CH - 1) return '0;
      else                       return w + IDX_W'(1);
   endfunction

   function automatic logic [NUM_CH-1:0] one_hot(input logic [IDX_W-1:0] w);
      return NUM_CH'(1) << w;
   endfunction

   // Scan downward so the last hit is the closest requester at or after rr_ptr.
   always_comb begin
      w_win_vld  = 1'b0;
      w_win_idx  = '0;
      w_win_len  = '0;
      w_win_port = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (ch_req[wrap_idx(int'(r_rr_ptr), k)]) begin
            w_win_vld  = 1'b1;
            w_win_idx  = IDX_W'(wrap_idx(int'(r_rr_ptr), k));
            w_win_len  = ch_len[wrap_idx(int'(r_rr_ptr), k)*16 +: 16];
            w_win_port = ch_dst_port[wrap_idx(int'(r_rr_ptr), k)*16 +: 16];
         end
      end
   end

   assign w_len_ok = (w_win_len != 16'd0) && (w_win_len <= 16'(MAX_LEN));

   always_comb begin
      w_dat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant[i]) w_dat = ch_payload_dat[i*8 +: 8];
      end
   end

   always_ff @(posedge clk_125m) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_owner   <= '0;
         r_grant   <= '0;
         r_done    <= '0;
         r_tx_en   <= 1'b0;
         r_len     <= '0;
         r_port    <= '0;
         r_len_err <= 1'b0;
         r_err_to  <= 1'b0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_done    <= '0;
         r_tx_en   <= 1'b0;
         r_len_err <= 1'b0;
         r_err_to  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  if (!w_len_ok) begin
                     r_done    <= one_hot(w_win_idx);
                     r_len_err <= 1'b1;
                     r_rr_ptr  <= next_ptr(w_win_idx);
                  end else begin
                     r_grant  <= one_hot(w_win_idx);
                     r_owner  <= w_win_idx;
                     r_len    <= w_win_len;
                     r_port   <= w_win_port;
                     r_tx_en  <= 1'b1;
                     r_to_cnt <= '0;
                     r_state  <= S_WAIT_DONE;
                  end
               end
            end
            S_WAIT_DONE: begin
               // tx_done takes priority over a timeout landing in the same cycle.
               if (tx_done || (r_to_cnt == TO_W'(TIMEOUT_CYC - 1))) begin
                  r_done    <= r_grant;
                  r_grant   <= '0;
                  r_rr_ptr  <= next_ptr(r_owner);
                  r_err_to  <= !tx_done;
                  r_gap_cnt <= '0;
                  r_state   <= S_GAP;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) r_state <= S_IDLE;
               else                                     r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ch_grant       = r_grant;
   assign ch_payload_req = r_grant & {NUM_CH{payload_req_i}};
   assign ch_done        = r_done;
   assign tx_en_pulse    = r_tx_en;
   assign tx_data_length = r_len;
   assign tx_dst_port    = r_port;
   assign payload_dat_o  = w_dat;
   assign busy           = (r_state != S_IDLE);
   assign len_err        = r_len_err;
   assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: launch, round-robin, length reject, timeout,
// payload routing and mid-packet reset, each with hand-computed expectations.
module tb_udp_tx_scheduler;

   logic        clk_125m = 1'b0;
   logic        rst;
   logic [1:0]  ch_req;
   logic [31:0] ch_len;
   logic [31:0] ch_dst_port;
   logic [15:0] ch_payload_dat;
   logic [1:0]  ch_grant;
   logic [1:0]  ch_payload_req;
   logic [1:0]  ch_done;
   logic        tx_en_pulse;
   logic [15:0] tx_data_length;
   logic [15:0] tx_dst_port;
   logic        tx_done;
   logic        payload_req_i;
   logic [7:0]  payload_dat_o;
   logic        busy;
   logic        len_err;
   logic        err_timeout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   udp_tx_scheduler #(.NUM_CH(2), .IFG_CYCLES(16), .TIMEOUT_CYC(4096), .MAX_LEN(1472)) dut (
      .clk_125m(clk_125m), .rst(rst), .ch_req(ch_req), .ch_len(ch_len),
      .ch_dst_port(ch_dst_port), .ch_payload_dat(ch_payload_dat), .ch_grant(ch_grant),
      .ch_payload_req(ch_payload_req), .ch_done(ch_done), .tx_en_pulse(tx_en_pulse),
      .tx_data_length(tx_data_length), .tx_dst_port(tx_dst_port), .tx_done(tx_done),
      .payload_req_i(payload_req_i), .payload_dat_o(payload_dat_o), .busy(busy),
      .len_err(len_err), .err_timeout(err_timeout)
   );

   always #4 clk_125m = ~clk_125m;
   always @(posedge clk_125m) cyc <= cyc + 1;

   task automatic tick();
      @(negedge clk_125m);
   endtask

   task automatic do_reset();
      rst = 1'b1; ch_req = '0; tx_done = 1'b0; payload_req_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_launch(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         tick();
         if (tx_en_pulse) seen = 1'b1;
      end
   endtask

   task automatic finish_pkt();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      repeat (18) tick();
   endtask

   task automatic test_reset();
      payload_req_i = 1'b1;
      tick();
      n_cmp++; if (ch_grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", ch_grant); end
      n_cmp++; if (ch_done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", ch_done); end
      n_cmp++; if (ch_payload_req !== 2'b00) begin n_err++; $display("FAIL reset_preq: got %b want 00", ch_payload_req); end
      n_cmp++; if ({tx_en_pulse, busy, len_err, err_timeout} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b want 0000", {tx_en_pulse, busy, len_err, err_timeout}); end
      n_cmp++; if (tx_data_length !== 16'd0) begin n_err++; $display("FAIL reset_len: got %0d want 0", tx_data_length); end
      n_cmp++; if (tx_dst_port !== 16'd0) begin n_err++; $display("FAIL reset_port: got %h want 0000", tx_dst_port); end
      n_cmp++; if (payload_dat_o !== 8'd0) begin n_err++; $display("FAIL reset_dat: got %h want 00", payload_dat_o); end
      payload_req_i = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single_launch();
      int launches, dones;
      ch_len = {16'd0, 16'd100}; ch_dst_port = {16'h0000, 16'h1F90}; ch_req = 2'b01;
      tick();
      n_cmp++; if (tx_en_pulse !== 1'b1) begin n_err++; $display("FAIL t1_launch: got %b want 1", tx_en_pulse); end
      n_cmp++; if (ch_grant !== 2'b01) begin n_err++; $display("FAIL t1_grant: got %b want 01", ch_grant); end
      n_cmp++; if (tx_data_length !== 16'd100) begin n_err++; $display("FAIL t1_len: got %0d want 100", tx_data_length); end
      n_cmp++; if (tx_dst_port !== 16'h1F90) begin n_err++; $display("FAIL t1_port: got %h want 1f90", tx_dst_port); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
      ch_req = 2'b00;
      tick();
      n_cmp++; if (tx_en_pulse !== 1'b0) begin n_err++; $display("FAIL t1_pulse_width: got %b want 0", tx_en_pulse); end
      n_cmp++; if (ch_grant !== 2'b01) begin n_err++; $display("FAIL t1_grant_hold: got %b want 01", ch_grant); end
      tick(); tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      n_cmp++; if (ch_done !== 2'b01) begin n_err++; $display("FAIL t1_done: got %b want 01", ch_done); end
      n_cmp++; if (ch_grant !== 2'b00) begin n_err++; $display("FAIL t1_release: got %b want 00", ch_grant); end
      ch_req = 2'b01; launches = 0; dones = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (tx_en_pulse) launches++;
         if (ch_done != 2'b00) dones++;
      end
      n_cmp++; if (launches !== 0) begin n_err++; $display("FAIL t1_gap_launch: got %0d want 0", launches); end
      n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL t1_done_width: got %0d extra want 0", dones); end
      tick();
      n_cmp++; if (tx_en_pulse !== 1'b1) begin n_err++; $display("FAIL t1_relaunch: got %b want 1", tx_en_pulse); end
      ch_req = 2'b00;
      finish_pkt();
   endtask

   task automatic test_back_to_back();
      bit seen;
      int last;
      logic [1:0] exp_g;
      do_reset();
      ch_len = {16'd200, 16'd64}; ch_dst_port = {16'h2000, 16'h1000}; ch_req = 2'b11;
      exp_g = 2'b01; last = 0;
      for (int p = 0; p < 4; p++) begin
         wait_launch(40, seen);
         n_cmp++; if (!seen) begin n_err++; $display("FAIL rr_launch%0d: got none want tx_en_pulse", p); end
         n_cmp++; if (ch_grant !== exp_g) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", p, ch_grant, exp_g); end
         n_cmp++; if (tx_data_length !== ((exp_g == 2'b01) ? 16'd64 : 16'd200)) begin
            n_err++; $display("FAIL rr_len%0d: got %0d want %0d", p, tx_data_length, (exp_g == 2'b01) ? 64 : 200); end
         if (p > 0) begin
            n_cmp++; if (cyc - last < 18) begin n_err++; $display("FAIL rr_spacing%0d: got %0d want >=18", p, cyc - last); end
         end
         last = cyc;
         tick(); tick();
         tx_done = 1'b1; tick(); tx_done = 1'b0;
         exp_g = {exp_g[0], exp_g[1]};
      end
      ch_req = 2'b00;
      repeat (20) tick();
   endtask

   task automatic test_len_err();
      do_reset();
      ch_len = {16'd100, 16'd0}; ch_dst_port = {16'h0, 16'h0050}; ch_req = 2'b01;
      tick();
      n_cmp++; if ({len_err, ch_done} !== 3'b101) begin n_err++; $display("FAIL len0_reject: got %b want 101", {len_err, ch_done}); end
      n_cmp++; if ({tx_en_pulse, ch_grant, busy} !== 4'b0000) begin
         n_err++; $display("FAIL len0_nolaunch: got %b want 0000", {tx_en_pulse, ch_grant, busy}); end
      ch_len[15:0] = 16'd1473;
      tick();
      n_cmp++; if ({len_err, ch_done} !== 3'b101) begin n_err++; $display("FAIL len1473_reject: got %b want 101", {len_err, ch_done}); end
      n_cmp++; if (tx_en_pulse !== 1'b0) begin n_err++; $display("FAIL len1473_nolaunch: got %b want 0", tx_en_pulse); end
      ch_len[15:0] = 16'd1472;
      tick();
      n_cmp++; if ({tx_en_pulse, ch_grant} !== 3'b101) begin n_err++; $display("FAIL len1472_launch: got %b want 101", {tx_en_pulse, ch_grant}); end
      n_cmp++; if (tx_data_length !== 16'd1472) begin n_err++; $display("FAIL len1472_len: got %0d want 1472", tx_data_length); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL len1472_err: got %b want 0", len_err); end
      ch_req = 2'b00;
      finish_pkt();
   endtask

   task automatic test_timeout();
      int bad, launches, dones;
      ch_len = {16'd500, 16'd1472}; ch_dst_port = {16'h3000, 16'h4000}; ch_req = 2'b10;
      tick();
      n_cmp++; if ({tx_en_pulse, ch_grant} !== 3'b110) begin n_err++; $display("FAIL to_launch: got %b want 110", {tx_en_pulse, ch_grant}); end
      ch_req = 2'b00; bad = 0;
      for (int i = 1; i < 4096; i++) begin
         tick();
         if (err_timeout || ch_done != 2'b00 || ch_grant != 2'b10) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL to_early: got %0d bad cycles want 0", bad); end
      tick();
      n_cmp++; if ({err_timeout, ch_done, ch_grant} !== 5'b11000) begin
         n_err++; $display("FAIL to_release: got %b want 11000", {err_timeout, ch_done, ch_grant}); end
      n_cmp++; if (tx_data_length !== 16'd500) begin n_err++; $display("FAIL to_len_hold: got %0d want 500", tx_data_length); end
      ch_req = 2'b01; tx_done = 1'b1; launches = 0; dones = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         tx_done = 1'b0;
         if (tx_en_pulse) launches++;
         if (ch_done != 2'b00 || err_timeout) dones++;
      end
      n_cmp++; if (launches !== 0) begin n_err++; $display("FAIL to_gap_launch: got %0d want 0", launches); end
      n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL to_gap_done: got %0d want 0", dones); end
      tick();
      n_cmp++; if ({tx_en_pulse, ch_grant} !== 3'b101) begin n_err++; $display("FAIL to_next_launch: got %b want 101", {tx_en_pulse, ch_grant}); end
      ch_req = 2'b00;
      repeat (4095) tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      n_cmp++; if ({err_timeout, ch_done} !== 3'b001) begin
         n_err++; $display("FAIL to_tie: got %b want 001", {err_timeout, ch_done}); end
      repeat (18) tick();
   endtask

   task automatic test_payload();
      do_reset();
      ch_len = {16'd100, 16'd100}; ch_req = 2'b10;
      tick();
      n_cmp++; if (ch_grant !== 2'b10) begin n_err++; $display("FAIL pl_grant: got %b want 10", ch_grant); end
      ch_req = 2'b00;
      for (int i = 0; i < 100; i++) begin
         payload_req_i = 1'b1;
         ch_payload_dat = {8'(i), 8'(8'hA5 ^ i)};
         #1;
         n_cmp++; if (ch_payload_req !== 2'b10) begin n_err++; $display("FAIL pl_req%0d: got %b want 10", i, ch_payload_req); end
         n_cmp++; if (payload_dat_o !== 8'(i)) begin n_err++; $display("FAIL pl_dat%0d: got %h want %h", i, payload_dat_o, 8'(i)); end
         tick();
      end
      payload_req_i = 1'b0; #1;
      n_cmp++; if (ch_payload_req !== 2'b00) begin n_err++; $display("FAIL pl_req_low: got %b want 00", ch_payload_req); end
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      payload_req_i = 1'b1; #1;
      n_cmp++; if (ch_payload_req !== 2'b00) begin n_err++; $display("FAIL pl_req_released: got %b want 00", ch_payload_req); end
      n_cmp++; if (payload_dat_o !== 8'd0) begin n_err++; $display("FAIL pl_dat_released: got %h want 00", payload_dat_o); end
      payload_req_i = 1'b0;
      repeat (18) tick();
   endtask

   task automatic test_reset_mid();
      ch_len = {16'd300, 16'd100}; ch_dst_port = {16'h5000, 16'h6000}; ch_req = 2'b01;
      tick();
      n_cmp++; if (ch_grant !== 2'b01) begin n_err++; $display("FAIL rm_first: got %b want 01", ch_grant); end
      ch_req = 2'b00;
      finish_pkt();
      ch_req = 2'b10;
      tick();
      n_cmp++; if ({tx_en_pulse, ch_grant} !== 3'b110) begin n_err++; $display("FAIL rm_second: got %b want 110", {tx_en_pulse, ch_grant}); end
      ch_req = 2'b00;
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if ({ch_grant, ch_done, busy, tx_en_pulse} !== 6'b000000) begin
         n_err++; $display("FAIL rm_ctrl: got %b want 000000", {ch_grant, ch_done, busy, tx_en_pulse}); end
      n_cmp++; if ({tx_data_length, tx_dst_port} !== 32'd0) begin
         n_err++; $display("FAIL rm_params: got %h want 00000000", {tx_data_length, tx_dst_port}); end
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      n_cmp++; if (ch_done !== 2'b00) begin n_err++; $display("FAIL rm_stale_done: got %b want 00", ch_done); end
      ch_req = 2'b11;
      tick();
      n_cmp++; if ({tx_en_pulse, ch_grant} !== 3'b101) begin n_err++; $display("FAIL rm_rrptr: got %b want 101", {tx_en_pulse, ch_grant}); end
      ch_req = 2'b00;
      finish_pkt();
   endtask

   initial begin
      rst = 1'b1; ch_req = '0; ch_len = '0; ch_dst_port = '0; ch_payload_dat = '0;
      tx_done = 1'b0; payload_req_i = 1'b0;
      test_reset();
      test_single_launch();
      test_back_to_back();
      test_len_err();
      test_timeout();
      test_payload();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
